// File: rtl/mc14500_pkg.sv
// Shared definitions for the MC14500B program sequencer.
//   seq_state_e  : sequencer states (HALT, FETCH, EXEC, JTGT)
//   OPC_MSB/LSB  : opcode field position within a ROM word
//   ADDR_FIELD_W : width of the instruction address field
package mc14500_pkg;

  typedef enum logic [1:0] {
    HALT  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    JTGT  = 2'd3
  } seq_state_e;

  localparam int OPC_MSB      = 7;
  localparam int OPC_LSB      = 4;
  localparam int ADDR_FIELD_W = 4;

endpackage

// File: rtl/mc14500_return_stack.sv
// LIFO of subroutine return addresses for the MC14500B sequencer.
// Ports:
//   clk, reset       : clock, asynchronous active-high reset (empties stack)
//   push, data_in    : store data_in on top; ignored when full
//   pop              : discard top entry; ignored when empty
//   data_out         : current top entry (zero when empty)
//   full, empty      : occupancy status
// Parameters: DEPTH (entries, >= 1), WIDTH (entry width).
module mc14500_return_stack #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] mem [DEPTH];

  assign empty = (cnt == '0);
  assign full  = (cnt == CW'(DEPTH));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (push && !full) begin
      cnt <= cnt + CW'(1);
    end else if (pop && !empty) begin
      cnt <= cnt - CW'(1);
    end
  end

  // Storage needs no reset: an entry is only visible once it has been written.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (push && !full && cnt == CW'(i)) begin
        mem[i] <= data_in;
      end
    end
  end

  always_comb begin
    data_out = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (cnt == CW'(i + 1)) begin
        data_out = mem[i];
      end
    end
  end

endmodule

// File: rtl/mc14500_program_sequencer.sv
// Program sequencer for an MC14500B one-bit controller system.
// Fetches ROM words, presents opcode/address to the ICU and output latch,
// strobes the latch write_disable, and handles JMP/RTN/FLGF flow.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   run                 : start pulse, only honoured in HALT
//   rom_addr, rom_data  : external combinational program ROM
//   instr, io_addr      : opcode and latch address registered at FETCH
//   latch_wd            : latch write_disable (low only in EXEC)
//   chip_enable         : latch chip enable (high only in EXEC)
//   jmp, rtn, flag_f    : ICU flags, sampled in EXEC (flag_f > jmp > rtn)
//   pc, halted          : program counter, HALT indication
//   stack_err           : sticky return-stack overflow/underflow
// Build option: define MC14500_SEQ_RETURN_STACK_EN to enable the return
// stack; without it JMP does not push, rtn is ignored and stack_err is 0.
//
// state | meaning
// ------+-------------------------------------------------------------
// HALT  | idle, waiting for run; latch disabled
// FETCH | capture opcode and io_addr from rom_data at pc
// EXEC  | latch write strobe active; act on ICU flags
// JTGT  | rom_data holds the jump target word; load it into pc
module mc14500_program_sequencer
  import mc14500_pkg::*;
#(
  parameter int PC_WIDTH      = 8,
  parameter int IO_ADDR_WIDTH = 3,
  parameter int STACK_DEPTH   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     run,
  output logic [PC_WIDTH-1:0]      rom_addr,
  input  logic [7:0]               rom_data,
  output logic [3:0]               instr,
  output logic [IO_ADDR_WIDTH-1:0] io_addr,
  output logic                     latch_wd,
  output logic                     chip_enable,
  input  logic                     jmp,
  input  logic                     rtn,
  input  logic                     flag_f,
  output logic [PC_WIDTH-1:0]      pc,
  output logic                     halted,
  output logic                     stack_err
);

  localparam logic [1:0] S_HALT  = HALT;
  localparam logic [1:0] S_FETCH = FETCH;
  localparam logic [1:0] S_EXEC  = EXEC;
  localparam logic [1:0] S_JTGT  = JTGT;

  logic [1:0]          state;
  logic [PC_WIDTH-1:0] pc_inc;
  logic [PC_WIDTH-1:0] jump_target;
  logic [PC_WIDTH-1:0] rtn_target;
  logic                rtn_take;
  logic                exec_st;

  assign exec_st     = (state == S_EXEC);
  assign pc_inc      = pc + PC_WIDTH'(1);
  assign rom_addr    = pc;
  assign halted      = (state == S_HALT);
  // Decoded straight from state so reset forces write_disable high
  // asynchronously and never produces a falling edge toward the latch.
  assign latch_wd    = !exec_st;
  assign chip_enable = exec_st;

  // Jump target word is zero-extended or truncated to the pc width.
  generate
    if (PC_WIDTH > 8) begin : g_tgt_wide
      assign jump_target = {{(PC_WIDTH-8){1'b0}}, rom_data};
    end else if (PC_WIDTH == 8) begin : g_tgt_same
      assign jump_target = rom_data;
    end else begin : g_tgt_narrow
      assign jump_target = rom_data[PC_WIDTH-1:0];
    end
  endgenerate

`ifdef MC14500_SEQ_RETURN_STACK_EN
  logic                stack_push;
  logic                stack_pop;
  logic                stack_full;
  logic                stack_empty;
  logic [PC_WIDTH-1:0] stack_top;
  logic [PC_WIDTH-1:0] pc_ret;
  logic                stack_err_q;

  // Return lands after the target word that follows the JMP opcode.
  assign pc_ret     = pc + PC_WIDTH'(2);
  assign stack_push = exec_st && !flag_f && jmp;
  assign stack_pop  = exec_st && !flag_f && !jmp && rtn;

  mc14500_return_stack #(
    .DEPTH (STACK_DEPTH),
    .WIDTH (PC_WIDTH)
  ) u_return_stack (
    .clk      (clk),
    .reset    (reset),
    .push     (stack_push),
    .pop      (stack_pop),
    .data_in  (pc_ret),
    .data_out (stack_top),
    .full     (stack_full),
    .empty    (stack_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stack_err_q <= 1'b0;
    end else if ((stack_push && stack_full) || (stack_pop && stack_empty)) begin
      stack_err_q <= 1'b1;
    end
  end

  assign stack_err  = stack_err_q;
  assign rtn_take   = rtn;
  // Underflow falls through to the next instruction.
  assign rtn_target = stack_empty ? pc_inc : stack_top;
`else
  logic unused_rtn;

  assign unused_rtn = rtn;
  assign stack_err  = 1'b0;
  assign rtn_take   = 1'b0;
  assign rtn_target = pc_inc;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_HALT;
      pc      <= '0;
      instr   <= '0;
      io_addr <= '0;
    end else begin
      case (state)
        S_HALT: begin
          if (run) begin
            state <= S_FETCH;
          end
        end
        S_FETCH: begin
          instr   <= rom_data[OPC_MSB:OPC_LSB];
          io_addr <= rom_data[IO_ADDR_WIDTH-1:0];
          state   <= S_EXEC;
        end
        S_EXEC: begin
          if (flag_f) begin
            // HALT presents the reset-time latch fields; only pc advances.
            pc      <= pc_inc;
            instr   <= '0;
            io_addr <= '0;
            state   <= S_HALT;
          end else if (jmp) begin
            pc    <= pc_inc;
            state <= S_JTGT;
          end else if (rtn_take) begin
            pc    <= rtn_target;
            state <= S_FETCH;
          end else begin
            pc    <= pc_inc;
            state <= S_FETCH;
          end
        end
        S_JTGT: begin
          pc    <= jump_target;
          state <= S_FETCH;
        end
        default: begin
          state <= S_HALT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mc14500_program_sequencer.sv
module tb_mc14500_program_sequencer;

  logic       clk;
  logic       reset;
  logic       run;
  logic [7:0] rom_addr;
  logic [7:0] rom_data;
  logic [3:0] instr;
  logic [2:0] io_addr;
  logic       latch_wd;
  logic       chip_enable;
  logic       jmp;
  logic       rtn;
  logic       flag_f;
  logic [7:0] pc;
  logic       halted;
  logic       stack_err;

  mc14500_program_sequencer #(
    .PC_WIDTH      (8),
    .IO_ADDR_WIDTH (3),
    .STACK_DEPTH   (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .instr       (instr),
    .io_addr     (io_addr),
    .latch_wd    (latch_wd),
    .chip_enable (chip_enable),
    .jmp         (jmp),
    .rtn         (rtn),
    .flag_f      (flag_f),
    .pc          (pc),
    .halted      (halted),
    .stack_err   (stack_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef MC14500_SEQ_RETURN_STACK_EN
  localparam bit STACK_ON = 1'b1;
`else
  localparam bit STACK_ON = 1'b0;
`endif

  // ROM and ICU flag model, both keyed by the program address.
  logic [7:0] rom     [256];
  logic       jmp_at  [256];
  logic       rtn_at  [256];
  logic       ff_at   [256];

  assign rom_data = rom[rom_addr];
  assign jmp      = jmp_at[pc];
  assign rtn      = rtn_at[pc];
  assign flag_f   = ff_at[pc];

  typedef struct {
    logic [7:0] pc;
    logic [3:0] instr;
    logic [2:0] io;
  } exp_t;

  exp_t exp_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   exec_seen = 0;
  int   wd_falls  = 0;

  task automatic check(input string name, input int act, input int expv);
    n_assert++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic expect_exec(input logic [7:0] p, input logic [3:0] i, input logic [2:0] a);
    exp_t e;
    e.pc = p; e.instr = i; e.io = a;
    exp_q.push_back(e);
  endtask

  task automatic clear_tables();
    for (int i = 0; i < 256; i++) begin
      rom[i] = 8'h00; jmp_at[i] = 1'b0; rtn_at[i] = 1'b0; ff_at[i] = 1'b0;
    end
  endtask

  // Monitor: every EXEC cycle is a presented instruction; compare to scoreboard.
  always @(negedge clk) begin
    if (!reset && chip_enable) begin
      exec_seen++;
      if (exp_q.size() == 0) begin
        check("unexpected_exec_pc", int'(pc), -1);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("exec_pc", int'(pc), int'(e.pc));
        check("exec_instr", int'(instr), int'(e.instr));
        check("exec_io_addr", int'(io_addr), int'(e.io));
        check("exec_latch_wd", int'(latch_wd), 0);
      end
    end
  end

  always @(negedge latch_wd) wd_falls++;

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_pc", int'(pc), 0);
    check("rst_instr", int'(instr), 0);
    check("rst_io_addr", int'(io_addr), 0);
    check("rst_latch_wd", int'(latch_wd), 1);
    check("rst_chip_enable", int'(chip_enable), 0);
    check("rst_halted", int'(halted), 1);
    check("rst_stack_err", int'(stack_err), 0);
    reset = 1'b0;
  endtask

  // Pulse run (held three cycles: the extra cycles must be ignored) and
  // wait, bounded, for the program to halt.
  task automatic run_to_halt(input string name);
    int cyc;
    @(negedge clk);
    run = 1'b1;
    @(negedge clk);
    check({name, "_fetch_wd"}, int'(latch_wd), 1);
    check({name, "_fetch_ce"}, int'(chip_enable), 0);
    repeat (2) @(negedge clk);
    run = 1'b0;
    cyc = 0;
    while (!halted && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check({name, "_halt_reached"}, int'(halted), 1);
  endtask

  initial begin
    reset = 1'b1;
    run   = 1'b0;
    clear_tables();
    #1;
    do_reset();

    // Phase 1: plain fetch, JMP, RTN (pop, pop, underflow), FLGF+JMP halt.
    rom[8'h00] = 8'h12; rom[8'h01] = 8'h35;
    rom[8'h02] = 8'hC7; rom[8'h03] = 8'h10; jmp_at[8'h02] = 1'b1;
    rom[8'h10] = 8'hC0; rom[8'h11] = 8'h40; jmp_at[8'h10] = 1'b1;
    rom[8'h40] = 8'h9B;
    rom[8'h41] = 8'hD0; rtn_at[8'h41] = 1'b1;
    rom[8'h12] = 8'hD1; rtn_at[8'h12] = 1'b1;
    rom[8'h04] = 8'hD2; rtn_at[8'h04] = 1'b1;
    rom[8'h05] = 8'hF6; ff_at[8'h05] = 1'b1; jmp_at[8'h05] = 1'b1;
    rom[8'h42] = 8'hA4; rtn_at[8'h42] = 1'b1;
    rom[8'h43] = 8'hE5; ff_at[8'h43] = 1'b1; jmp_at[8'h43] = 1'b1;

    expect_exec(8'h00, 4'h1, 3'd2);
    expect_exec(8'h01, 4'h3, 3'd5);
    expect_exec(8'h02, 4'hC, 3'd7);
    expect_exec(8'h10, 4'hC, 3'd0);
    expect_exec(8'h40, 4'h9, 3'd3);
    expect_exec(8'h41, 4'hD, 3'd0);
    if (STACK_ON) begin
      expect_exec(8'h12, 4'hD, 3'd1);
      expect_exec(8'h04, 4'hD, 3'd2);
      expect_exec(8'h05, 4'hF, 3'd6);
    end else begin
      expect_exec(8'h42, 4'hA, 3'd4);
      expect_exec(8'h43, 4'hE, 3'd5);
    end
    run_to_halt("p1");
    check("p1_halt_pc", int'(pc), STACK_ON ? 8'h06 : 8'h44);
    check("p1_stack_err", int'(stack_err), STACK_ON ? 1 : 0);
    check("p1_halt_wd", int'(latch_wd), 1);
    check("p1_queue_drained", exp_q.size(), 0);

    // Phase 2: five nested JMPs against a 4-deep stack, then unwind.
    do_reset();
    clear_tables();
    rom[8'h00] = 8'hC1; rom[8'h01] = 8'h20; jmp_at[8'h00] = 1'b1;
    rom[8'h20] = 8'hC2; rom[8'h21] = 8'h30; jmp_at[8'h20] = 1'b1;
    rom[8'h30] = 8'hC3; rom[8'h31] = 8'h50; jmp_at[8'h30] = 1'b1;
    rom[8'h50] = 8'hC4; rom[8'h51] = 8'h60; jmp_at[8'h50] = 1'b1;
    rom[8'h60] = 8'hC5; rom[8'h61] = 8'h70; jmp_at[8'h60] = 1'b1;
    rom[8'h70] = 8'hD6; rtn_at[8'h70] = 1'b1;
    rom[8'h52] = 8'hD7; rtn_at[8'h52] = 1'b1;
    rom[8'h32] = 8'hD0; rtn_at[8'h32] = 1'b1;
    rom[8'h22] = 8'hD1; rtn_at[8'h22] = 1'b1;
    rom[8'h02] = 8'hF2; ff_at[8'h02] = 1'b1;
    rom[8'h71] = 8'hF3; ff_at[8'h71] = 1'b1;

    expect_exec(8'h00, 4'hC, 3'd1);
    expect_exec(8'h20, 4'hC, 3'd2);
    expect_exec(8'h30, 4'hC, 3'd3);
    expect_exec(8'h50, 4'hC, 3'd4);
    expect_exec(8'h60, 4'hC, 3'd5);
    expect_exec(8'h70, 4'hD, 3'd6);
    if (STACK_ON) begin
      expect_exec(8'h52, 4'hD, 3'd7);
      expect_exec(8'h32, 4'hD, 3'd0);
      expect_exec(8'h22, 4'hD, 3'd1);
      expect_exec(8'h02, 4'hF, 3'd2);
    end else begin
      expect_exec(8'h71, 4'hF, 3'd3);
    end
    run_to_halt("p2");
    check("p2_halt_pc", int'(pc), STACK_ON ? 8'h03 : 8'h72);
    check("p2_stack_err", int'(stack_err), STACK_ON ? 1 : 0);
    check("p2_queue_drained", exp_q.size(), 0);

    // Phase 3: pc wrap 0xFF -> 0x00, then reset in the middle of EXEC.
    do_reset();
    clear_tables();
    rom[8'h00] = 8'hC0; rom[8'h01] = 8'hFF; jmp_at[8'h00] = 1'b1;
    rom[8'hFF] = 8'h5A;
    expect_exec(8'h00, 4'hC, 3'd0);
    expect_exec(8'hFF, 4'h5, 3'd2);
    expect_exec(8'h00, 4'hC, 3'd0);
    begin
      int n_ex;
      int cyc;
      @(negedge clk);
      run = 1'b1;
      @(negedge clk);
      run = 1'b0;
      n_ex = 0;
      cyc  = 0;
      while (n_ex < 3 && cyc < 100) begin
        if (chip_enable) n_ex++;
        if (n_ex < 3) begin
          @(negedge clk);
          cyc++;
        end
      end
      check("p3_third_exec_reached", n_ex, 3);
      check("p3_mid_exec_wd", int'(latch_wd), 0);
      #2;
      reset = 1'b1;
      #1;
      check("p3_async_wd", int'(latch_wd), 1);
      check("p3_async_pc", int'(pc), 0);
      check("p3_async_halted", int'(halted), 1);
      check("p3_async_ce", int'(chip_enable), 0);
      check("p3_async_instr", int'(instr), 0);
      check("p3_async_stack_err", int'(stack_err), 0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      check("p3_stays_halted", int'(halted), 1);
    end
    check("p3_queue_drained", exp_q.size(), 0);
    check("latch_falls_match_execs", wd_falls, exec_seen);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
